// File: rtl/e203_exu_fpu_fcmp_pipe.sv
// ---------------------------------------------------------------------------
// e203_exu_fpu_fcmp_pipe
//
// Two-stage elastic floating-point compare/select unit (FEQ/FLT/FLE/FMIN/FMAX)
// for IEEE-754 binary formats with configurable exponent/mantissa widths.
// Stage 1 registers the operands together with their classification and a
// magnitude comparison; stage 2 registers the final result, flags and tag.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   i_flush               kill all in-flight operations (and any same-cycle input)
//   i_valid/i_ready       dispatch handshake
//   i_op                  0=EQ 1=LT 2=LE 3=MIN 4=MAX, 5..7 reserved
//   i_rs1/i_rs2/i_tag     operands a/b and opaque tag
//   o_valid/o_ready       writeback handshake
//   o_wdat                0/1 for compares, selected operand for MIN/MAX
//   o_fflags              {NV,DZ,OF,UF,NX}; only NV is produced
//   o_tag                 tag of the result
// ---------------------------------------------------------------------------
module e203_exu_fpu_fcmp_pipe #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    parameter  int TAG_W = 5,
    localparam int FLEN  = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [2:0]       i_op,
    input  logic [FLEN-1:0]  i_rs1,
    input  logic [FLEN-1:0]  i_rs2,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [FLEN-1:0]  o_wdat,
    output logic [4:0]       o_fflags,
    output logic [TAG_W-1:0] o_tag
);

    typedef enum logic [2:0] {
        OP_EQ  = 3'd0,
        OP_LT  = 3'd1,
        OP_LE  = 3'd2,
        OP_MIN = 3'd3,
        OP_MAX = 3'd4
    } op_e;

    localparam logic [FLEN-1:0] CANON_NAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // ---------------- stage 1 state ----------------
    logic             s1_v_q, s1_v_d;
    logic [2:0]       s1_op_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [FLEN-1:0]  s1_a_q, s1_b_q;
    logic             s1_a_nan_q, s1_a_snan_q, s1_a_zero_q;
    logic             s1_b_nan_q, s1_b_snan_q, s1_b_zero_q;
    logic             s1_mag_lt_q, s1_mag_eq_q;

    // ---------------- stage 2 state ----------------
    logic             s2_v_q, s2_v_d;
    logic [FLEN-1:0]  s2_wdat_q, s2_wdat_d;
    logic [4:0]       s2_fflags_q, s2_fflags_d;
    logic [TAG_W-1:0] s2_tag_q;

    // ---------------- handshake ----------------
    logic s2_ready, s1_ready, accept, s2_load;

    assign s2_ready = ~s2_v_q | o_ready;
    assign s1_ready = ~s1_v_q | s2_ready;
    assign i_ready  = s1_ready & ~i_flush;
    assign accept   = i_valid & i_ready;
    assign s2_load  = s1_v_q & s2_ready & ~i_flush;

    // ---------------- input classification ----------------
    logic a_nan, a_snan, a_zero, b_nan, b_snan, b_zero;

    assign a_nan  = (&i_rs1[FLEN-2:MAN_W]) & (|i_rs1[MAN_W-1:0]);
    assign b_nan  = (&i_rs2[FLEN-2:MAN_W]) & (|i_rs2[MAN_W-1:0]);
    assign a_snan = a_nan & ~i_rs1[MAN_W-1];
    assign b_snan = b_nan & ~i_rs2[MAN_W-1];
    assign a_zero = ~|i_rs1[FLEN-2:0];
    assign b_zero = ~|i_rs2[FLEN-2:0];

    // ---------------- stage 2 result logic ----------------
    logic a_neg, b_neg, both_zero, any_nan, any_snan;
    logic ord_lt, ord_eq, tot_lt;

    assign a_neg     = s1_a_q[FLEN-1];
    assign b_neg     = s1_b_q[FLEN-1];
    assign both_zero = s1_a_zero_q & s1_b_zero_q;
    assign any_nan   = s1_a_nan_q | s1_b_nan_q;
    assign any_snan  = s1_a_snan_q | s1_b_snan_q;

    // Ordering of non-NaN operands where +0 == -0. Negative operands invert
    // the magnitude order.
    assign ord_eq = both_zero | ((a_neg == b_neg) & s1_mag_eq_q);
    assign ord_lt = (a_neg != b_neg) ? (a_neg & ~both_zero)
                  : (a_neg ? (~s1_mag_lt_q & ~s1_mag_eq_q) : s1_mag_lt_q);

    // MIN/MAX additionally order -0 below +0.
    assign tot_lt = ord_lt | (both_zero & a_neg & ~b_neg);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        s2_wdat_d   = '0;
        s2_fflags_d = '0;
        case (s1_op_q)
            OP_EQ: begin
                s2_wdat_d      = {{(FLEN-1){1'b0}}, ~any_nan & ord_eq};
                s2_fflags_d[4] = any_snan;
            end
            OP_LT: begin
                s2_wdat_d      = {{(FLEN-1){1'b0}}, ~any_nan & ord_lt};
                s2_fflags_d[4] = any_nan;
            end
            OP_LE: begin
                s2_wdat_d      = {{(FLEN-1){1'b0}}, ~any_nan & (ord_lt | ord_eq)};
                s2_fflags_d[4] = any_nan;
            end
            OP_MIN, OP_MAX: begin
                if (s1_a_nan_q && s1_b_nan_q)
                    s2_wdat_d = CANON_NAN;
                else if (s1_a_nan_q)
                    s2_wdat_d = s1_b_q;
                else if (s1_b_nan_q)
                    s2_wdat_d = s1_a_q;
                else if (s1_op_q == OP_MIN)
                    s2_wdat_d = tot_lt ? s1_a_q : s1_b_q;
                else
                    s2_wdat_d = tot_lt ? s1_b_q : s1_a_q;
                s2_fflags_d[4] = any_snan;
            end
            default: ;  // reserved ops: zero result and flags
        endcase
    end

    // ---------------- valid next-state ----------------
    always_comb begin
        s1_v_d = s1_v_q;
        s2_v_d = s2_v_q;
        if (i_flush) begin
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
        end else begin
            if (s2_ready) s2_v_d = s1_v_q;
            if (s1_ready) s1_v_d = i_valid;
        end
    end

    // ---------------- registers ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: payload registers are cleared too, because the outputs are
            // driven straight from stage 2 and must read zero out of reset.
            s1_v_q      <= 1'b0;
            s1_op_q     <= '0;
            s1_tag_q    <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_a_nan_q  <= 1'b0;
            s1_a_snan_q <= 1'b0;
            s1_a_zero_q <= 1'b0;
            s1_b_nan_q  <= 1'b0;
            s1_b_snan_q <= 1'b0;
            s1_b_zero_q <= 1'b0;
            s1_mag_lt_q <= 1'b0;
            s1_mag_eq_q <= 1'b0;
            s2_v_q      <= 1'b0;
            s2_wdat_q   <= '0;
            s2_fflags_q <= '0;
            s2_tag_q    <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            if (accept) begin
                s1_op_q     <= i_op;
                s1_tag_q    <= i_tag;
                s1_a_q      <= i_rs1;
                s1_b_q      <= i_rs2;
                s1_a_nan_q  <= a_nan;
                s1_a_snan_q <= a_snan;
                s1_a_zero_q <= a_zero;
                s1_b_nan_q  <= b_nan;
                s1_b_snan_q <= b_snan;
                s1_b_zero_q <= b_zero;
                s1_mag_lt_q <= i_rs1[FLEN-2:0] <  i_rs2[FLEN-2:0];
                s1_mag_eq_q <= i_rs1[FLEN-2:0] == i_rs2[FLEN-2:0];
            end
            if (s2_load) begin
                s2_wdat_q   <= s2_wdat_d;
                s2_fflags_q <= s2_fflags_d;
                s2_tag_q    <= s1_tag_q;
            end
        end
    end

    assign o_valid  = s2_v_q;
    assign o_wdat   = s2_wdat_q;
    assign o_fflags = s2_fflags_q;
    assign o_tag    = s2_tag_q;

endmodule

// File: tb/tb_e203_exu_fpu_fcmp_pipe.sv
// ---------------------------------------------------------------------------
// Testbench for e203_exu_fpu_fcmp_pipe (binary32 configuration).
// Expected results are pushed to a scoreboard queue when an operation is
// accepted and popped by a monitor when the unit hands a result downstream.
// ---------------------------------------------------------------------------
module tb_e203_exu_fpu_fcmp_pipe;

    localparam logic [31:0] P0  = 32'h0000_0000;
    localparam logic [31:0] N0  = 32'h8000_0000;
    localparam logic [31:0] ONE = 32'h3F80_0000;
    localparam logic [31:0] TWO = 32'h4000_0000;
    localparam logic [31:0] M1  = 32'hBF80_0000;
    localparam logic [31:0] M2  = 32'hC000_0000;
    localparam logic [31:0] QN  = 32'h7FC0_0000;
    localparam logic [31:0] SN  = 32'h7F80_0001;
    localparam logic [31:0] T   = 32'h0000_0001;
    localparam logic [31:0] F   = 32'h0000_0000;
    localparam logic [4:0]  NV  = 5'h10;
    localparam logic [4:0]  OK  = 5'h00;

    localparam logic [2:0] EQ = 3'd0, LT = 3'd1, LE = 3'd2, MIN = 3'd3, MAX = 3'd4;

    logic        clk = 1'b0;
    logic        rst, i_flush, i_valid, i_ready, o_valid, o_ready;
    logic [2:0]  i_op;
    logic [31:0] i_rs1, i_rs2, o_wdat;
    logic [4:0]  i_tag, o_tag, o_fflags;

    typedef struct packed {
        logic [31:0] w;
        logic [4:0]  f;
        logic [4:0]  t;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    e203_exu_fpu_fcmp_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (i_flush),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_op     (i_op),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_tag    (i_tag),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_wdat   (o_wdat),
        .o_fflags (o_fflags),
        .o_tag    (o_tag)
    );

    always #5 clk = ~clk;

    // Monitor: a result transfers at the next rising edge when o_valid and
    // o_ready are both high at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_valid === 1'b1 && o_ready === 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_result: got wdat=%h fflags=%h tag=%0d, required no output",
                             o_wdat, o_fflags, o_tag);
                end else begin
                    e = sb.pop_front();
                    if ({o_wdat, o_fflags, o_tag} !== e) begin
                        n_bad++;
                        $display("FAIL result: got wdat=%h fflags=%h tag=%0d, required wdat=%h fflags=%h tag=%0d",
                                 o_wdat, o_fflags, o_tag, e.w, e.f, e.t);
                    end
                end
            end
        end
    end

    // Drive one operation and hold it until accepted. Returns one step after
    // the accepting edge with i_valid low, so a following call issues in the
    // very next cycle.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] ew, input logic [4:0] ef,
                         input bit push);
        int waited;
        waited  = 0;
        i_valid = 1'b1;
        i_op    = op;
        i_rs1   = a;
        i_rs2   = b;
        i_tag   = tag;
        forever begin
            @(negedge clk);
            if (i_ready === 1'b1) break;
            waited++;
            if (waited > 50) begin
                n_vec++;
                n_bad++;
                $display("FAIL accept_timeout: tag %0d never accepted, required i_ready=1", tag);
                i_valid = 1'b0;
                return;
            end
        end
        if (push) sb.push_back('{w: ew, f: ef, t: tag});
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; o_ready = 1'b1;
        i_op = '0; i_rs1 = '0; i_rs2 = '0; i_tag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({o_valid, o_wdat, o_fflags, o_tag} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%b wdat=%h fflags=%h tag=%0d, required all 0",
                     o_valid, o_wdat, o_fflags, o_tag);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (i_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got i_ready=%b, required 1", i_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_signed_zero();
        issue(EQ, P0, N0, 5'd1, T, OK, 1);
        // Now in cycle N+1: result must not be visible yet, then appear in N+2.
        @(negedge clk);
        n_vec++;
        if (o_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_early: got o_valid=%b in cycle N+1, required 0", o_valid);
        end
        @(negedge clk);
        n_vec++;
        if (o_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL latency_n2: got o_valid=%b in cycle N+2, required 1", o_valid);
        end
        @(posedge clk);
        #1;
        issue(LT, P0, N0, 5'd2, F, OK, 1);
        issue(LE, N0, P0, 5'd3, T, OK, 1);
        issue(LT, N0, P0, 5'd4, F, OK, 1);
        drain();
    endtask

    task automatic test_nan();
        issue(LT, QN, ONE, 5'd5,  F, NV, 1);
        issue(EQ, QN, ONE, 5'd6,  F, OK, 1);
        issue(EQ, SN, ONE, 5'd7,  F, NV, 1);
        issue(LE, ONE, SN, 5'd8,  F, NV, 1);
        issue(EQ, QN, QN,  5'd9,  F, OK, 1);
        drain();
    endtask

    task automatic test_ordering();
        issue(LT, M2,  M1,  5'd10, T, OK, 1);
        issue(LT, M1,  M2,  5'd11, F, OK, 1);
        issue(LE, ONE, ONE, 5'd12, T, OK, 1);
        issue(LT, ONE, ONE, 5'd13, F, OK, 1);
        issue(EQ, ONE, ONE, 5'd14, T, OK, 1);
        issue(EQ, ONE, TWO, 5'd15, F, OK, 1);
        issue(LT, ONE, TWO, 5'd16, T, OK, 1);
        issue(LE, TWO, ONE, 5'd17, F, OK, 1);
        issue(LT, M1,  ONE, 5'd18, T, OK, 1);
        issue(LT, ONE, M1,  5'd19, F, OK, 1);
        issue(LE, M1,  M1,  5'd20, T, OK, 1);
        issue(EQ, M1,  ONE, 5'd21, F, OK, 1);
        issue(3'd5, ONE, TWO, 5'd22, F, OK, 1);
        issue(3'd7, SN,  SN,  5'd23, F, OK, 1);
        drain();
    endtask

    task automatic test_minmax();
        issue(MIN, N0,  P0,  5'd1,  N0,  OK, 1);
        issue(MAX, N0,  P0,  5'd2,  P0,  OK, 1);
        issue(MIN, P0,  N0,  5'd3,  N0,  OK, 1);
        issue(MAX, P0,  N0,  5'd4,  P0,  OK, 1);
        issue(MIN, QN,  TWO, 5'd5,  TWO, OK, 1);
        issue(MAX, SN,  QN,  5'd6,  QN,  NV, 1);
        issue(MIN, ONE, SN,  5'd7,  ONE, NV, 1);
        issue(MIN, 32'hFFC0_0001, QN, 5'd8, QN, OK, 1);
        issue(MAX, SN,  SN,  5'd9,  QN,  NV, 1);
        issue(MIN, M2,  M1,  5'd10, M2,  OK, 1);
        issue(MAX, M2,  M1,  5'd11, M1,  OK, 1);
        issue(MAX, ONE, M2,  5'd12, ONE, OK, 1);
        issue(MIN, TWO, ONE, 5'd13, ONE, OK, 1);
        drain();
    endtask

    task automatic test_back_to_back();
        o_ready = 1'b0;
        // cycle 0: first op accepted into an empty pipe
        i_valid = 1'b1; i_op = LT; i_rs1 = M2; i_rs2 = M1; i_tag = 5'd1;
        @(negedge clk);
        n_vec++;
        if (i_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_accept1: got i_ready=%b, required 1", i_ready);
        end
        sb.push_back('{w: T, f: OK, t: 5'd1});
        @(posedge clk);
        #1;
        // cycle 1: second op accepted while the first moves to stage 2
        i_op = MAX; i_rs1 = ONE; i_rs2 = TWO; i_tag = 5'd2;
        @(negedge clk);
        n_vec++;
        if (i_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_accept2: got i_ready=%b, required 1", i_ready);
        end
        sb.push_back('{w: TWO, f: OK, t: 5'd2});
        @(posedge clk);
        #1;
        // cycles 2,3: pipe full and stalled; third op must wait, output held
        i_op = EQ; i_rs1 = SN; i_rs2 = ONE; i_tag = 5'd3;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_vec++;
            if (i_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_ready_drop: got i_ready=%b in stall cycle %0d, required 0", i_ready, c);
            end
            n_vec++;
            if ({o_valid, o_wdat, o_fflags, o_tag} !== {1'b1, T, OK, 5'd1}) begin
                n_bad++;
                $display("FAIL bp_hold: got valid=%b wdat=%h fflags=%h tag=%0d, required 1/%h/%h/1",
                         o_valid, o_wdat, o_fflags, o_tag, T, OK);
            end
            @(posedge clk);
            #1;
        end
        // cycle 4: release; third op enters while the first drains
        o_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (i_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_resume: got i_ready=%b, required 1", i_ready);
        end
        sb.push_back('{w: F, f: NV, t: 5'd3});
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        // results 2 and 3 must follow on consecutive cycles
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_vec++;
            if (o_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL bp_no_bubble: got o_valid=%b in drain cycle %0d, required 1", o_valid, c);
            end
        end
        drain();
    endtask

    task automatic test_flush();
        o_ready = 1'b0;
        issue(MAX, ONE, TWO, 5'd20, F, OK, 0);
        issue(LT,  M2,  M1,  5'd21, F, OK, 0);
        // stage 2 holds op 20, stage 1 holds op 21; a third op is offered
        i_flush = 1'b1;
        i_valid = 1'b1; i_op = EQ; i_rs1 = ONE; i_rs2 = ONE; i_tag = 5'd22;
        @(negedge clk);
        n_vec++;
        if (i_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_ready: got i_ready=%b during flush, required 0", i_ready);
        end
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        o_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++;
            if (o_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL flush_kill: got o_valid=%b tag=%0d %0d cycles after flush, required 0",
                         o_valid, o_tag, c + 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_rst_mid();
        o_ready = 1'b0;
        issue(MAX, ONE, M2, 5'd7, F, OK, 0);
        issue(EQ,  SN,  ONE, 5'd9, F, OK, 0);
        @(negedge clk);
        n_vec++;
        if ({o_valid, o_wdat, o_tag} !== {1'b1, ONE, 5'd7}) begin
            n_bad++;
            $display("FAIL rst_pre: got valid=%b wdat=%h tag=%0d, required 1/%h/7",
                     o_valid, o_wdat, o_tag, ONE);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        o_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({o_valid, o_wdat, o_fflags, o_tag} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: got valid=%b wdat=%h fflags=%h tag=%0d, required all 0",
                     o_valid, o_wdat, o_fflags, o_tag);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if (o_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_mid_kill: got o_valid=%b tag=%0d, required 0", o_valid, o_tag);
            end
        end
        @(posedge clk);
        #1;
        issue(LE, M1, ONE, 5'd30, T, OK, 1);
        @(negedge clk);
        n_vec++;
        if (o_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_latency_early: got o_valid=%b in cycle N+1, required 0", o_valid);
        end
        @(negedge clk);
        n_vec++;
        if (o_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_latency_n2: got o_valid=%b in cycle N+2, required 1", o_valid);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_signed_zero();
        test_nan();
        test_ordering();
        test_minmax();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Absolute time bound in case a handshake wedges outside a bounded wait.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule
